// File: rtl/dma_block_scheduler.sv
// dma_block_scheduler
//
// Shares the SD card block-read DMA engine between the IDE sector buffer
// (requester 0) and the CDDA audio buffer (requester 1). One requester is
// picked per block with round-robin arbitration. Its LBA is issued to the SD
// card interface, and the broadcast DMA strobe is gated so that only the owner
// captures data. At the end of the block the owner receives a done pulse or an
// err pulse. Runs in the 2x CPU clock domain.
//
// Optional feature macro: DMA_SCHED_TIMEOUT_EN
//   When defined, a 23-bit watchdog aborts a block that has not completed
//   TIMEOUT_CYCLES cycles after ISSUE. The block ends with the err pulse.
//   When undefined, WAIT_BUSY and XFER wait indefinitely.
//
// Ports:
//   clk           in   system clock (2x CPU clock)
//   reset_        in   asynchronous active-low reset
//   ide_req       in   IDE requests one block
//   ide_lba       in   IDE block address, valid while ide_req is high
//   ide_ack       out  pulse: IDE LBA latched
//   ide_done      out  pulse: IDE block completed OK
//   ide_err       out  pulse: IDE block failed
//   cdda_*        -    same set for the CDDA buffer
//   cpu_hold      in   blocks new grants while high
//   sd_cmd_start  out  pulse: start a block read
//   sd_cmd_lba    out  latched LBA of the current owner
//   sd_busy       in   SD interface busy with a block
//   sd_error      in   SD error flag, sampled when sd_busy falls
//   dma_strobe    in   SD DMA byte strobe (broadcast)
//   ide_dma_en    out  IDE may capture dma_strobe
//   cdda_dma_en   out  CDDA may capture dma_strobe
//   grant         out  one-hot owner {cdda, ide}; 00 when idle
module dma_block_scheduler #(
    parameter int unsigned LBA_W          = 32,
    parameter int unsigned BLOCK_BYTES    = 512,
    parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             ide_req,
    input  logic [LBA_W-1:0] ide_lba,
    output logic             ide_ack,
    output logic             ide_done,
    output logic             ide_err,
    input  logic             cdda_req,
    input  logic [LBA_W-1:0] cdda_lba,
    output logic             cdda_ack,
    output logic             cdda_done,
    output logic             cdda_err,
    input  logic             cpu_hold,
    output logic             sd_cmd_start,
    output logic [LBA_W-1:0] sd_cmd_lba,
    input  logic             sd_busy,
    input  logic             sd_error,
    input  logic             dma_strobe,
    output logic             ide_dma_en,
    output logic             cdda_dma_en,
    output logic [1:0]       grant
);

    // Reject parameter values the strobe counter and watchdog cannot represent.
    if (BLOCK_BYTES == 0 || BLOCK_BYTES > 512 ||
        (BLOCK_BYTES & (BLOCK_BYTES - 1)) != 0 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 32'h007F_FFFF) begin : g_bad_params
        $fatal(1, "dma_block_scheduler: unsupported BLOCK_BYTES or TIMEOUT_CYCLES");
    end

    localparam logic [9:0] BLOCK_CNT = 10'(BLOCK_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_XFER,
        S_DONE
    } state_e;

    state_e           state_q;
    logic             own_cdda_q;    // current owner: 0 = IDE, 1 = CDDA
    logic             last_cdda_q;   // previous owner, used to break ties
    logic [9:0]       cnt_q;
    logic             ovf_q;

    logic             ide_ack_q;
    logic             ide_done_q;
    logic             ide_err_q;
    logic             cdda_ack_q;
    logic             cdda_done_q;
    logic             cdda_err_q;
    logic             sd_cmd_start_q;
    logic [LBA_W-1:0] sd_cmd_lba_q;
    logic             ide_dma_en_q;
    logic             cdda_dma_en_q;
    logic [1:0]       grant_q;

    logic [9:0]       cnt_d;
    logic             ovf_d;
    logic             pick_valid_d;
    logic             pick_cdda_d;
    logic             blk_end_d;
    logic             blk_err_d;
    logic             timeout_hit;

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam logic [22:0] WD_LAST = 23'(TIMEOUT_CYCLES - 1);
    logic [22:0] wd_q;
    // wd_q equals the number of cycles elapsed since ISSUE, so ending on
    // WD_LAST places DONE exactly TIMEOUT_CYCLES cycles after ISSUE.
    assign timeout_hit = (wd_q == WD_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Strobe counter saturates at one block; any further strobe sets the
    // sticky overflow flag instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (dma_strobe) begin
            if (cnt_q == BLOCK_CNT) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 10'd1;
            end
        end
    end

    // Round-robin pick: a tie goes to the requester that did not own the
    // previous block.
    always_comb begin
        pick_valid_d = 1'b0;
        pick_cdda_d  = 1'b0;
        if (!cpu_hold) begin
            if (ide_req && cdda_req) begin
                pick_valid_d = 1'b1;
                pick_cdda_d  = ~last_cdda_q;
            end else if (ide_req) begin
                pick_valid_d = 1'b1;
            end else if (cdda_req) begin
                pick_valid_d = 1'b1;
                pick_cdda_d  = 1'b1;
            end
        end
    end

    // End-of-block decision. The strobe arriving in the cycle where sd_busy
    // falls is already included through cnt_d/ovf_d.
    always_comb begin
        blk_end_d = 1'b0;
        blk_err_d = 1'b0;
        if (state_q == S_WAIT_BUSY || state_q == S_XFER) begin
            if (timeout_hit) begin
                blk_end_d = 1'b1;
                blk_err_d = 1'b1;
            end else if (state_q == S_XFER && !sd_busy) begin
                blk_end_d = 1'b1;
                blk_err_d = sd_error || (cnt_d != BLOCK_CNT) || ovf_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q        <= S_IDLE;
            own_cdda_q     <= 1'b0;
            last_cdda_q    <= 1'b1;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            ide_ack_q      <= 1'b0;
            ide_done_q     <= 1'b0;
            ide_err_q      <= 1'b0;
            cdda_ack_q     <= 1'b0;
            cdda_done_q    <= 1'b0;
            cdda_err_q     <= 1'b0;
            sd_cmd_start_q <= 1'b0;
            sd_cmd_lba_q   <= '0;
            ide_dma_en_q   <= 1'b0;
            cdda_dma_en_q  <= 1'b0;
            grant_q        <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
            wd_q           <= '0;
`endif
        end else begin
            ide_ack_q      <= 1'b0;
            ide_done_q     <= 1'b0;
            ide_err_q      <= 1'b0;
            cdda_ack_q     <= 1'b0;
            cdda_done_q    <= 1'b0;
            cdda_err_q     <= 1'b0;
            sd_cmd_start_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (pick_valid_d) begin
                        own_cdda_q     <= pick_cdda_d;
                        sd_cmd_lba_q   <= pick_cdda_d ? cdda_lba : ide_lba;
                        grant_q        <= pick_cdda_d ? 2'b10 : 2'b01;
                        // ISSUE outputs are registered here so they are
                        // visible for exactly the ISSUE cycle.
                        sd_cmd_start_q <= 1'b1;
                        ide_ack_q      <= ~pick_cdda_d;
                        cdda_ack_q     <= pick_cdda_d;
                        ide_dma_en_q   <= ~pick_cdda_d;
                        cdda_dma_en_q  <= pick_cdda_d;
                        cnt_q          <= '0;
                        ovf_q          <= 1'b0;
                        state_q        <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    cnt_q   <= '0;
                    ovf_q   <= 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
                    wd_q    <= 23'd1;
`endif
                    state_q <= S_WAIT_BUSY;
                end

                S_WAIT_BUSY, S_XFER: begin
                    cnt_q <= cnt_d;
                    ovf_q <= ovf_d;
`ifdef DMA_SCHED_TIMEOUT_EN
                    wd_q  <= wd_q + 23'd1;
`endif
                    if (blk_end_d) begin
                        grant_q       <= '0;
                        ide_dma_en_q  <= 1'b0;
                        cdda_dma_en_q <= 1'b0;
                        ide_done_q    <= ~own_cdda_q & ~blk_err_d;
                        ide_err_q     <= ~own_cdda_q &  blk_err_d;
                        cdda_done_q   <=  own_cdda_q & ~blk_err_d;
                        cdda_err_q    <=  own_cdda_q &  blk_err_d;
                        state_q       <= S_DONE;
                    end else if (state_q == S_WAIT_BUSY && sd_busy) begin
                        state_q <= S_XFER;
                    end
                end

                S_DONE: begin
                    last_cdda_q <= own_cdda_q;
                    state_q     <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ide_ack      = ide_ack_q;
    assign ide_done     = ide_done_q;
    assign ide_err      = ide_err_q;
    assign cdda_ack     = cdda_ack_q;
    assign cdda_done    = cdda_done_q;
    assign cdda_err     = cdda_err_q;
    assign sd_cmd_start = sd_cmd_start_q;
    assign sd_cmd_lba   = sd_cmd_lba_q;
    assign ide_dma_en   = ide_dma_en_q;
    assign cdda_dma_en  = cdda_dma_en_q;
    assign grant        = grant_q;

endmodule

// File: doc/dma_block_scheduler.md
Name: dma_block_scheduler

Overview:
- Shares the SD card block-read DMA engine between two requesters: the IDE sector buffer (requester 0) and the CDDA audio buffer (requester 1).
- Picks one requester per 512-byte block with round-robin arbitration and issues the block read to the SD card interface.
- Gates the broadcast DMA strobe so that only the owning buffer captures data.
- Reports completion or error back to the owner.
- Clocked by the 2x CPU clock domain, alongside the IDE, CDDA and SD card interfaces.

Parameters:
- LBA_W, 32, width of the block address.
- BLOCK_BYTES, 512, DMA strobes expected per block. Must be a power of two, at most 512.
- TIMEOUT_CYCLES, 4194304, watchdog limit in clk cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock (2x CPU clock).
- reset_  in  1  asynchronous, active-low reset.
- ide_req  in  1  IDE requests one block.
- ide_lba  in  LBA_W  block address for IDE; valid while ide_req is high.
- ide_ack  out  1  one-cycle pulse: IDE LBA has been latched.
- ide_done  out  1  one-cycle pulse: IDE block completed OK.
- ide_err  out  1  one-cycle pulse: IDE block failed.
- cdda_req, cdda_lba, cdda_ack, cdda_done, cdda_err: same as the IDE set, for CDDA.
- cpu_hold  in  1  high blocks new grants.
- sd_cmd_start  out  1  one-cycle pulse: start a block read.
- sd_cmd_lba  out  LBA_W  latched LBA of the current owner.
- sd_busy  in  1  SD card interface is busy with a block.
- sd_error  in  1  SD card error flag; sampled when sd_busy falls.
- dma_strobe  in  1  SD card DMA byte strobe.
- ide_dma_en  out  1  IDE may capture dma_strobe.
- cdda_dma_en  out  1  CDDA may capture dma_strobe.
- grant  out  2  one-hot owner {cdda, ide}; 00 when idle. Readable by the CPU.

Behaviour:
- Reset (asynchronous, while reset_=0):
  - All outputs are 0, sd_cmd_lba is 0, state is IDLE, strobe count is 0.
  - last_grant resets to CDDA, so the first tie goes to IDE.
  - Reset asserted mid-transfer aborts the transfer silently: no done or err pulse.
- IDLE:
  - If cpu_hold=1, stay in IDLE.
  - Otherwise, if exactly one req is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - On a grant: latch the owner and its LBA, set grant, go to ISSUE.
  - req is sampled only in IDLE.
- ISSUE (1 cycle):
  - Pulse sd_cmd_start and the owner's ack.
  - Assert the owner's dma_en and clear the strobe count.
  - Go to WAIT_BUSY.
  - The requester may drop req after ack. If req is still high in a later IDLE, it is a new request.
- WAIT_BUSY:
  - Wait for sd_busy=1, then go to XFER.
  - A dma_strobe seen here is counted.
- XFER:
  - Each dma_strobe increments an 10-bit count.
  - A strobe arriving when the count is already BLOCK_BYTES sets a sticky overflow flag.
  - When sd_busy=0, go to DONE.
  - Error condition: sd_error=1, or count != BLOCK_BYTES, or overflow.
  - A strobe in the same cycle that sd_busy falls is counted.
- DONE (1 cycle):
  - Pulse the owner's done, or its err if the error condition holds.
  - Drop dma_en and grant to 0, set last_grant to the owner, go to IDLE.
  - The next grant can happen on the following cycle. Minimum spacing between two sd_cmd_start pulses is 4 cycles.
- Outside ISSUE through XFER:
  - dma_strobe is ignored.
  - Both dma_en outputs are 0.
- cpu_hold has no effect once a transfer has started.

Optional Feature:
- Macro: DMA_SCHED_TIMEOUT_EN.
- With the macro defined:
  - A 23-bit watchdog counts cycles in WAIT_BUSY and XFER.
  - When it reaches TIMEOUT_CYCLES, go to DONE with err forced, regardless of sd_busy.
  - The watchdog clears in ISSUE.
- Without the macro:
  - No watchdog logic.
  - WAIT_BUSY and XFER wait indefinitely.

Test Plan:
- Single IDE request: ide_req=1, ide_lba=0x00001234 -> ide_ack on the cycle after acceptance; sd_cmd_start with sd_cmd_lba=0x00001234; grant=01. Model raises sd_busy, sends 512 strobes, drops busy -> exactly one ide_done, no ide_err, grant=00.
- Arbitration: ide_req and cdda_req both high from reset -> IDE served first, then CDDA. Repeat with both still high -> order IDE, CDDA, IDE, CDDA. cdda_dma_en is never high while grant=01.
- Errors:
  - 511 strobes -> cdda_err.
  - 513 strobes -> cdda_err.
  - sd_error=1 when busy falls -> err.
  - No done pulse in any of these cases.
- cpu_hold=1 with ide_req=1 for 100 cycles -> no ack and no sd_cmd_start. Release hold -> grant on the next cycle. Raise hold mid-XFER -> transfer completes normally.
- reset_ low mid-XFER, after 200 strobes -> all outputs 0 immediately, no done/err. After release, a pending cdda_req and ide_req tie is granted to IDE.
- Timeout, with DMA_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=1000: sd_busy held high -> ide_err exactly 1000 cycles after ISSUE. Without the macro: no err after 5000 cycles.
